// File: rtl/sipo_deserializer.sv
// sipo_deserializer: LSB-first serial-to-parallel word assembler feeding a valid/ready holding register.
// Latency: a word appears on dout/dout_valid one clock after its last bit is strobed.
// Backpressure: input is never stalled; a word completing while dout is held unaccepted is dropped (overrun pulse).
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   din, din_valid          serial bit (LSB first), sampled when din_valid=1
//   dout, dout_valid,       assembled word and its valid/ready handshake
//   dout_ready
//   busy                    a partial frame is in progress (bit counter != 0)
//   overrun                 one-cycle pulse when a completed word is dropped
//   parity_err              parity mismatch of the word on dout, qualified by dout_valid
//
// Optional feature macro: SIPO_PARITY_CHECK_EN
//   Defined   : each frame carries one extra even-parity bit after the data bits;
//               mismatches are reported on parity_err (word still delivered).
//   Undefined : frames are WIDTH bits, parity_err is tied low.

module sipo_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic [WIDTH-1:0] word;
  logic             take_bit;
  logic             frame_done;
  logic             load;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (din_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (din_valid && (cnt == LAST_BIT)) begin
`ifdef SIPO_PARITY_CHECK_EN
          state_nxt = PARITY;
`else
          state_nxt = IDLE;
`endif
        end
      end
      PARITY: begin
        if (din_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // take_bit: strobe lands in the data shift register.
  // frame_done: strobe is the last bit of the frame (data or parity bit).
  always_comb begin
    take_bit   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE, SHIFT: begin
        take_bit = din_valid;
`ifndef SIPO_PARITY_CHECK_EN
        // cnt is 0 in IDLE and WIDTH>=2, so only SHIFT can match here.
        frame_done = din_valid && (cnt == LAST_BIT);
`endif
      end
      PARITY: begin
        frame_done = din_valid;
      end
      default: begin
        take_bit   = 1'b0;
        frame_done = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  // Bit is written at position cnt; a compare loop avoids an index whose
  // width differs from the log2 of WIDTH.
  always_comb begin
    sreg_nxt = sreg;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt == CNT_W'(i)) sreg_nxt[i] = din;
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    if (frame_done) begin
      cnt_nxt = '0;
    end else if (din_valid) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

`ifdef SIPO_PARITY_CHECK_EN
  // Data bits are all in sreg by the time the parity bit arrives.
  assign word = sreg;
`else
  // The last data bit is still on din at completion; merge it in directly.
  assign word = sreg_nxt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      if (take_bit) sreg <= sreg_nxt;
      cnt  <= cnt_nxt;
      busy <= (cnt_nxt != '0);
    end
  end

  // ---------------------------------------------------------------- output holding register
  // A completed word is taken only if the holding register is empty or is
  // being emptied on this same edge; otherwise it is dropped.
  assign load = frame_done && (!dout_valid || dout_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= frame_done && !load;
      if (load) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

`ifdef SIPO_PARITY_CHECK_EN
  logic perr_q;

  // Even parity over data + parity bit; updated only when dout loads, so a
  // dropped word never disturbs the flag belonging to the held word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else if (load) begin
      perr_q <= ^{sreg, din};
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
`ifdef SIPO_PARITY_CHECK_EN
  localparam int FRAME = WIDTH + 1;
  localparam bit PAR   = 1'b1;
`else
  localparam int FRAME = WIDTH;
  localparam bit PAR   = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             din;
  logic             din_valid;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: received bits of the current frame kept as a list,
  // the word is packed only once the list reaches the frame length.
  bit               mq[$];
  logic [WIDTH-1:0] m_dout  = '0;
  bit               m_valid = 1'b0;
  bit               m_over  = 1'b0;
  bit               m_perr  = 1'b0;

  typedef struct {
    bit               din;
    bit               dv;
    bit               rdy;
    logic [WIDTH-1:0] e_dout;
    bit               e_valid;
    bit               e_busy;
  } vec_t;

  vec_t tbl[FRAME+2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit fbit(input logic [WIDTH-1:0] w, input bit pbit, input int i);
    if (i < WIDTH) return w[i];
    return pbit;
  endfunction

  function automatic bit even_pbit(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_over  = 1'b0;
    m_perr  = 1'b0;
  endtask

  task automatic model_edge(input bit d, input bit dv, input bit rdy);
    bit               done;
    bit               pe;
    logic [WIDTH-1:0] w;
    done   = 1'b0;
    m_over = 1'b0;
    if (dv) begin
      mq.push_back(d);
      if (mq.size() == FRAME) done = 1'b1;
    end
    if (done) begin
      w  = '0;
      pe = 1'b0;
      for (int i = 0; i < WIDTH; i++) w[i] = mq[i];
      foreach (mq[i]) pe ^= mq[i];
      mq.delete();
      if (m_valid && !rdy) begin
        m_over = 1'b1;
      end else begin
        m_dout  = w;
        m_valid = 1'b1;
        m_perr  = PAR ? pe : 1'b0;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_model();
    check("mdl_dout",       32'(dout),       32'(m_dout));
    check("mdl_dout_valid", 32'(dout_valid), 32'(m_valid));
    check("mdl_busy",       32'(busy),       32'(mq.size() != 0));
    check("mdl_overrun",    32'(overrun),    32'(m_over));
    check("mdl_parity_err", 32'(parity_err), 32'(m_perr));
  endtask

  // One clock: drive inputs, advance the model on the edge, compare 1 ns later.
  task automatic cycle(input bit d, input bit dv, input bit rdy);
    din        = d;
    din_valid  = dv;
    dout_ready = rdy;
    @(posedge clk);
    model_edge(d, dv, rdy);
    #1;
    compare_model();
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input bit pbit, input int maxgap,
                            input bit rdy, input bit last_rdy);
    for (int i = 0; i < FRAME; i++) begin
      int g;
      g = int'($urandom_range(0, maxgap));
      repeat (g) cycle(1'($urandom_range(0, 1)), 1'b0, rdy);
      cycle(fbit(w, pbit, i), 1'b1, (i == FRAME - 1) ? last_rdy : rdy);
    end
  endtask

  // Asserts reset between edges and checks outputs clear before the next edge.
  task automatic reset_mid_cycle();
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_dout",       32'(dout),       32'(0));
    check("rst_async_dout_valid", 32'(dout_valid), 32'(0));
    check("rst_async_busy",       32'(busy),       32'(0));
    check("rst_async_overrun",    32'(overrun),    32'(0));
    check("rst_async_parity_err", 32'(parity_err), 32'(0));
    model_reset();
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a5;
    a5 = 8'hA5;

    reset      = 1'b1;
    din        = 1'b0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;

    // Back-to-back A5 frame followed by an accept and an idle ready cycle.
    for (int i = 0; i < FRAME; i++) begin
      tbl[i].din     = fbit(a5, even_pbit(a5), i);
      tbl[i].dv      = 1'b1;
      tbl[i].rdy     = 1'b0;
      tbl[i].e_dout  = (i == FRAME - 1) ? a5 : '0;
      tbl[i].e_valid = (i == FRAME - 1);
      tbl[i].e_busy  = (i != FRAME - 1);
    end
    for (int i = FRAME; i < FRAME + 2; i++) begin
      tbl[i].din     = 1'b1;
      tbl[i].dv      = 1'b0;
      tbl[i].rdy     = 1'b1;
      tbl[i].e_dout  = a5;
      tbl[i].e_valid = 1'b0;
      tbl[i].e_busy  = 1'b0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout",       32'(dout),       32'(0));
    check("reset_dout_valid", 32'(dout_valid), 32'(0));
    check("reset_busy",       32'(busy),       32'(0));
    check("reset_overrun",    32'(overrun),    32'(0));
    check("reset_parity_err", 32'(parity_err), 32'(0));
    reset = 1'b0;
    model_reset();

    // Table-driven A5 frame
    for (int r = 0; r < FRAME + 2; r++) begin
      cycle(tbl[r].din, tbl[r].dv, tbl[r].rdy);
      check($sformatf("tbl%0d_dout", r),  32'(dout),       32'(tbl[r].e_dout));
      check($sformatf("tbl%0d_valid", r), 32'(dout_valid), 32'(tbl[r].e_valid));
      check($sformatf("tbl%0d_busy", r),  32'(busy),       32'(tbl[r].e_busy));
    end

    // 3C with random gaps, held until accepted
    send_frame(8'h3C, even_pbit(8'h3C), 5, 1'b0, 1'b0);
    check("t3_dout",  32'(dout),       32'(8'h3C));
    check("t3_valid", 32'(dout_valid), 32'(1));
    repeat (6) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    check("t3_hold_dout",  32'(dout),       32'(8'h3C));
    check("t3_hold_valid", 32'(dout_valid), 32'(1));
    cycle(1'b0, 1'b0, 1'b1);
    check("t3_accept_valid", 32'(dout_valid), 32'(0));

    // Overrun: 11 held, 22 dropped
    send_frame(8'h11, even_pbit(8'h11), 2, 1'b0, 1'b0);
    send_frame(8'h22, even_pbit(8'h22), 2, 1'b0, 1'b0);
    check("t4_overrun",    32'(overrun), 32'(1));
    check("t4_dout_kept",  32'(dout),    32'(8'h11));
    check("t4_busy_clear", 32'(busy),    32'(0));
    cycle(1'b0, 1'b0, 1'b0);
    check("t4_overrun_pulse_end", 32'(overrun), 32'(0));
    // Completion coinciding with accept of the held word
    send_frame(8'h22, even_pbit(8'h22), 2, 1'b0, 1'b1);
    check("t4b_dout",     32'(dout),       32'(8'h22));
    check("t4b_valid",    32'(dout_valid), 32'(1));
    check("t4b_overrun",  32'(overrun),    32'(0));
    cycle(1'b0, 1'b0, 1'b1);

    // Reset after 3 bits of a frame, then F0 must assemble without stale bits
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    check("t5_busy_partial", 32'(busy), 32'(1));
    reset_mid_cycle();
    send_frame(8'hF0, even_pbit(8'hF0), 0, 1'b0, 1'b0);
    check("t5_dout",  32'(dout),       32'(8'hF0));
    check("t5_valid", 32'(dout_valid), 32'(1));
    cycle(1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_CHECK_EN
    send_frame(8'h07, 1'b1, 1, 1'b0, 1'b0);
    check("t6_good_dout", 32'(dout),       32'(8'h07));
    check("t6_good_perr", 32'(parity_err), 32'(0));
    cycle(1'b0, 1'b0, 1'b1);
    send_frame(8'h07, 1'b0, 1, 1'b0, 1'b0);
    check("t6_bad_dout",  32'(dout),       32'(8'h07));
    check("t6_bad_perr",  32'(parity_err), 32'(1));
    cycle(1'b0, 1'b0, 1'b1);
`endif

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
